// File: rtl/hazard_ctrl.sv
// hazard_ctrl: sequencing controller for the 5-stage MIPS pipeline. It handles load-use
//   stalls, branch/jump squashes, and a full-pipeline freeze with timeout on data-memory waits.
// Latency: control outputs are Mealy, i.e. combinational from state and inputs in the same
//   cycle. mem_timeout, stall_count and flush_count are registered.
// Backpressure: mem_ready low freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. After WAIT_TIMEOUT
//   wait cycles the block enters a sticky error state, which only rst_n clears.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_rs/id_rt/id_uses_rt, ex_mem_read/ex_rt   load-use detection operands
//   ex_jump, mem_branch_taken                    wrong-path squash requests
//   mem_req, mem_ready                           data-memory handshake
//   pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_flush, pipe_freeze
//   mem_timeout                                  sticky timeout flag
//   stall_count, flush_count                     saturating performance counters
// Optional macro HAZ_PERF_CNT_EN: when it is defined, the performance counters are built.
//   When it is undefined, both counters read 0. Control behaviour is the same in both cases.
module hazard_ctrl #(
   parameter int WAIT_TIMEOUT = 15,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             ex_jump,
   input  logic             mem_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_write,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic             pipe_freeze,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       to_err;
   logic       lu, mem_wait, freeze;

   // Register $zero is never a real destination, so a load into it cannot create a hazard.
   assign lu = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign mem_wait = mem_req & ~mem_ready;
   assign freeze   = ((state == RUN) && mem_wait) ||
                     ((state == MEM_WAIT) && !mem_ready) ||
                     (state == ERR);

   // Next state and wait counter.
   // wait_cnt counts freeze cycles. The RUN cycle that first sees the wait is cycle 1.
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      to_err       = 1'b0;
      case (state)
         RUN: begin
            if (mem_wait) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = 8'd0;
            end else if (wait_cnt == 8'(WAIT_TIMEOUT)) begin
               state_nxt = ERR;
               to_err    = 1'b1;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         default: state_nxt = ERR;
      endcase
   end

   // Pipeline controls. The priority order is freeze, then flush, then stall.
   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_write  = 1'b1;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      pipe_freeze = 1'b0;
      if (freeze) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         pipe_freeze = 1'b1;
      end else if (mem_branch_taken) begin
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
      end else if (ex_jump) begin
         // The jump is already in EX and is architecturally valid. Only IF and ID are wrong-path.
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
      end else if (lu) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_bubble = 1'b1;
      end
      // While reset is held, load nops everywhere so the pipeline drains clean.
      if (!rst_n) begin
         pc_write    = 1'b0;
         ifid_write  = 1'b0;
         idex_write  = 1'b0;
         ifid_flush  = 1'b1;
         idex_bubble = 1'b1;
         exmem_flush = 1'b1;
         pipe_freeze = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         wait_cnt    <= 8'd0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= mem_timeout | to_err;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   logic flush_evt, stall_evt;
   assign flush_evt = ~freeze & (mem_branch_taken | ex_jump);
   assign stall_evt = ~freeze & ~mem_branch_taken & ~ex_jump & lu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count <= '0;
         flush_count <= '0;
      end else begin
         if (stall_evt && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + CNT_W'(1);
         if (flush_evt && (flush_count != {CNT_W{1'b1}}))
            flush_count <= flush_count + CNT_W'(1);
      end
   end
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int CW = 4;
`ifdef HAZ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // The control vector is ordered {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
   // exmem_flush, pipe_freeze}.
   localparam logic [6:0] C_RST   = 7'b0010110;
   localparam logic [6:0] C_RUN   = 7'b1101000;
   localparam logic [6:0] C_STALL = 7'b0001100;
   localparam logic [6:0] C_BR    = 7'b1111110;
   localparam logic [6:0] C_JMP   = 7'b1111100;
   localparam logic [6:0] C_FRZ   = 7'b0000001;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    id_rs, id_rt, ex_rt;
   logic          id_uses_rt, ex_mem_read, ex_jump, mem_branch_taken, mem_req, mem_ready;
   logic          pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_flush;
   logic          pipe_freeze, mem_timeout;
   logic [CW-1:0] stall_count, flush_count;
   logic [6:0]    ctl;

   int n_cmp = 0;
   int n_err = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   always #5 clk = ~clk;

   assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_flush,
                 pipe_freeze};

   hazard_ctrl #(.WAIT_TIMEOUT(4), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_jump(ex_jump),
      .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
      .pipe_freeze(pipe_freeze), .mem_timeout(mem_timeout),
      .stall_count(stall_count), .flush_count(flush_count)
   );

   function automatic logic [CW-1:0] cnt_exp(input int n);
      int s;
      s = (n > 15) ? 15 : n;
      return PERF ? CW'(s) : '0;
   endfunction

   task automatic idle();
      id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_rt = 5'd0; ex_jump = 1'b0;
      mem_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (ctl !== C_RST) begin
         n_err++; $display("FAIL reset_ctl got=%b want=%b", ctl, C_RST);
      end
      n_cmp++;
      if ({mem_timeout, stall_count, flush_count} !== '0) begin
         n_err++;
         $display("FAIL reset_regs got to=%b st=%0d fl=%0d want 0", mem_timeout, stall_count,
                  flush_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== C_RUN) begin
         n_err++; $display("FAIL run_after_reset got=%b want=%b", ctl, C_RUN);
      end
   endtask

   task automatic test_load_use();
      // Load-use hazard on the rs operand.
      @(negedge clk);
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      #1;
      n_cmp++;
      if (ctl !== C_STALL) begin
         n_err++; $display("FAIL lu_rs got=%b want=%b", ctl, C_STALL);
      end
      exp_stall++;
      // The load has moved to MEM, so the hazard is gone.
      @(negedge clk);
      idle();
      #1;
      n_cmp++;
      if (ctl !== C_RUN) begin
         n_err++; $display("FAIL lu_release got=%b want=%b", ctl, C_RUN);
      end
      n_cmp++;
      if (stall_count !== cnt_exp(exp_stall)) begin
         n_err++; $display("FAIL lu_count got=%0d want=%0d", stall_count, cnt_exp(exp_stall));
      end
      // Load-use hazard on the rt operand.
      @(negedge clk);
      ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== C_STALL) begin
         n_err++; $display("FAIL lu_rt got=%b want=%b", ctl, C_STALL);
      end
      exp_stall++;
   endtask

   task automatic test_no_stall();
      @(negedge clk);
      idle();
      ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
      #1;
      n_cmp++;
      if (ctl !== C_RUN) begin
         n_err++; $display("FAIL nostall_r0 got=%b want=%b", ctl, C_RUN);
      end
      @(negedge clk);
      ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
      #1;
      n_cmp++;
      if (ctl !== C_RUN) begin
         n_err++; $display("FAIL nostall_rt_unused got=%b want=%b", ctl, C_RUN);
      end
      @(negedge clk);
      idle();
      n_cmp++;
      if (stall_count !== cnt_exp(exp_stall)) begin
         n_err++;
         $display("FAIL nostall_count got=%0d want=%0d", stall_count, cnt_exp(exp_stall));
      end
   endtask

   task automatic test_flush();
      // A taken branch arrives together with a load-use hazard. The flush wins.
      @(negedge clk);
      mem_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
      #1;
      n_cmp++;
      if (ctl !== C_BR) begin
         n_err++; $display("FAIL branch_lu got=%b want=%b", ctl, C_BR);
      end
      exp_flush++;
      @(negedge clk);
      idle();
      ex_jump = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== C_JMP) begin
         n_err++; $display("FAIL jump got=%b want=%b", ctl, C_JMP);
      end
      exp_flush++;
      @(negedge clk);
      idle();
      n_cmp++;
      if ({stall_count, flush_count} !== {cnt_exp(exp_stall), cnt_exp(exp_flush)}) begin
         n_err++;
         $display("FAIL flush_counts got st=%0d fl=%0d want st=%0d fl=%0d", stall_count,
                  flush_count, cnt_exp(exp_stall), cnt_exp(exp_flush));
      end
   endtask

   task automatic test_mem_wait();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle();
         mem_req = 1'b1;
         // A branch during the freeze is masked and must not be counted.
         mem_branch_taken = (i == 1);
         #1;
         n_cmp++;
         if (ctl !== C_FRZ) begin
            n_err++; $display("FAIL wait_freeze%0d got=%b want=%b", i, ctl, C_FRZ);
         end
      end
      @(negedge clk);
      idle();
      mem_req = 1'b1; mem_ready = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== C_RUN) begin
         n_err++; $display("FAIL wait_advance got=%b want=%b", ctl, C_RUN);
      end
      // Back in RUN: mem_ready low with no request must not freeze.
      @(negedge clk);
      idle();
      #1;
      n_cmp++;
      if ({ctl, mem_timeout} !== {C_RUN, 1'b0}) begin
         n_err++; $display("FAIL wait_back_run got=%b/%b want=%b/0", ctl, mem_timeout, C_RUN);
      end
      n_cmp++;
      if (flush_count !== cnt_exp(exp_flush)) begin
         n_err++;
         $display("FAIL wait_masked_flush got=%0d want=%0d", flush_count, cnt_exp(exp_flush));
      end
   endtask

   task automatic test_timeout();
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         idle();
         mem_req = 1'b1;
         #1;
         n_cmp++;
         if ({ctl, mem_timeout} !== {C_FRZ, 1'b0}) begin
            n_err++; $display("FAIL to_cycle%0d got=%b/%b want=%b/0", i, ctl, mem_timeout, C_FRZ);
         end
      end
      @(negedge clk);
      idle();
      mem_ready = 1'b1;
      #1;
      n_cmp++;
      if ({ctl, mem_timeout} !== {C_FRZ, 1'b1}) begin
         n_err++; $display("FAIL to_err got=%b/%b want=%b/1", ctl, mem_timeout, C_FRZ);
      end
      @(negedge clk);
      #1;
      n_cmp++;
      if ({ctl, mem_timeout} !== {C_FRZ, 1'b1}) begin
         n_err++; $display("FAIL to_err_hold got=%b/%b want=%b/1", ctl, mem_timeout, C_FRZ);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({ctl, mem_timeout, flush_count} !== {C_RST, 1'b0, {CW{1'b0}}}) begin
         n_err++;
         $display("FAIL to_reset got=%b/%b/%0d want=%b/0/0", ctl, mem_timeout, flush_count,
                  C_RST);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      exp_stall = 0; exp_flush = 0;
      #1;
      n_cmp++;
      if (ctl !== C_RUN) begin
         n_err++; $display("FAIL to_recover got=%b want=%b", ctl, C_RUN);
      end
   endtask

   task automatic test_reset_mid_wait();
      repeat (2) begin
         @(negedge clk);
         idle();
         mem_req = 1'b1;
      end
      @(negedge clk);
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      // If the state had stayed in MEM_WAIT, mem_ready=0 would still freeze here.
      n_cmp++;
      if (ctl !== C_RUN) begin
         n_err++; $display("FAIL reset_mid_wait got=%b want=%b", ctl, C_RUN);
      end
   endtask

   task automatic test_saturation();
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         idle();
         ex_jump = 1'b1;
         exp_flush++;
         if (i == 10) begin
            n_cmp++;
            if (flush_count !== cnt_exp(9)) begin
               n_err++; $display("FAIL sat_mid got=%0d want=%0d", flush_count, cnt_exp(9));
            end
         end
      end
      @(negedge clk);
      idle();
      n_cmp++;
      if ({stall_count, flush_count} !== {cnt_exp(0), cnt_exp(exp_flush)}) begin
         n_err++;
         $display("FAIL sat_final got st=%0d fl=%0d want st=%0d fl=%0d", stall_count,
                  flush_count, cnt_exp(0), cnt_exp(exp_flush));
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_no_stall();
      test_flush();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives write-enable, flush and bubble controls for PC, IF/ID, ID/EX and EX/MEM.
- Detects load-use hazards, squashes wrong-path instructions on taken branch (resolved in MEM) and jump (resolved in EX), and freezes the whole pipeline while data memory is not ready, with a timeout.
- The ID/EX register gains a write enable (idex_write) and a synchronous bubble input (idex_bubble, zeroes all control fields) driven by this block.

Parameters:
- WAIT_TIMEOUT, 15, max consecutive MEM_WAIT cycles before ERR (1..255).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs  in  5  rs field of the instruction in ID (IF/ID bits 25:21).
- id_rt  in  5  rt field of the instruction in ID (bits 20:16).
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq, sw).
- ex_mem_read  in  1  memRead of the instruction in EX (ID/EX output).
- ex_rt  in  5  rt destination of the instruction in EX (ID/EX outi20_16).
- ex_jump  in  1  jump of the instruction in EX.
- mem_branch_taken  in  1  branch AND zero of the instruction in MEM.
- mem_req  in  1  memRead OR memWrite of the instruction in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a nop.
- idex_write  out  1  ID/EX load enable.
- idex_bubble  out  1  ID/EX loads zeroed controls.
- exmem_flush  out  1  EX/MEM loads zeroed controls.
- pipe_freeze  out  1  EX/MEM and MEM/WB hold their contents.
- mem_timeout  out  1  sticky error flag (registered).
- stall_count  out  CNT_W  load-use stall cycles (registered).
- flush_count  out  CNT_W  flush cycles (registered).

Behaviour:
- States: RUN, MEM_WAIT, ERR. Control outputs are Mealy (combinational from state and inputs). mem_timeout and the counters are registered.
- While rst_n=0:
  - state=RUN, wait_cnt=0, counters=0, mem_timeout=0.
  - pc_write=0, ifid_write=0, idex_write=0.
  - ifid_flush=1, idex_bubble=1, exmem_flush=1, pipe_freeze=0.
  - Effect: the pipeline fills with nops during reset.
- Definitions:
  - lu = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
  - wait = mem_req & ~mem_ready.
- Priority is freeze > flush > stall.
- Freeze (state RUN with wait, or state MEM_WAIT with ~mem_ready, or state ERR):
  - pipe_freeze=1.
  - pc_write=ifid_write=idex_write=0.
  - All flush/bubble outputs 0. Freeze masks any branch, jump or lu in the same cycle; these re-evaluate once the pipeline moves.
- Else, if mem_branch_taken:
  - ifid_flush=1, idex_bubble=1, exmem_flush=1, pc_write=1 (branch target), ifid_write=1, idex_write=1.
  - flush_count++.
- Else, if ex_jump:
  - ifid_flush=1, idex_bubble=1, exmem_flush=0, pc_write=1.
  - flush_count++.
- Else, if lu:
  - pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1.
  - stall_count++.
  - Exactly one stall cycle: the next cycle the load is in MEM, so lu deasserts.
- Else: all writes=1, all flush/bubble outputs=0.
- Branch and lu in the same cycle: flush wins, no stall counted.
- Transitions:
  - RUN, wait=1 → MEM_WAIT, wait_cnt←1.
  - RUN with mem_req & mem_ready in the same cycle: no freeze, stay RUN.
  - MEM_WAIT, mem_ready=1: the pipeline advances this cycle under the normal rules above → RUN, wait_cnt←0.
  - MEM_WAIT, mem_ready=0 and wait_cnt==WAIT_TIMEOUT → ERR, mem_timeout←1.
  - MEM_WAIT, mem_ready=0 otherwise: wait_cnt++.
  - ERR is held until rst_n is asserted.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-MEM_WAIT or in ERR: immediate return to the reset values above.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: stall_count and flush_count are implemented as described.
- Undefined: both outputs are tied to 0 and no counter flops are synthesized. All control behaviour is identical in both cases.

Test Plan:
- Load-use on rs: ex_mem_read=1, ex_rt=8, id_rs=8 → one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle all writes=1; stall_count=1.
- No stall when ex_rt=0, or when id_uses_rt=0 with id_rt=ex_rt=9 and id_rs=3 → pc_write=1, stall_count unchanged.
- mem_branch_taken=1 together with lu=1 → ifid_flush=idex_bubble=exmem_flush=1, pc_write=1; flush_count=1, stall_count=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 → pipe_freeze=1 for 3 cycles; advance on the 4th cycle; state returns to RUN; mem_timeout=0.
- Timeout, WAIT_TIMEOUT=4: mem_ready held at 0 → ERR entered after the 5th freeze cycle, mem_timeout=1, pipe_freeze stays 1; deassert then reassert rst_n → all outputs at reset values, mem_timeout=0.
- Saturation, CNT_W=4: 20 ex_jump pulses → flush_count=15. With HAZ_PERF_CNT_EN undefined → both counters read 0.
